// File: rtl/sha256_sched_pkg.sv
// Shared types and constants for the SHA-256 job scheduler.
package sha256_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_ARM   = 3'd2,
    S_RUN   = 3'd3,
    S_ACK   = 3'd4
  } sched_state_t;

  localparam int unsigned ADDR_W_DEFAULT = 16;

  // Non-engine cycles spent per job: IDLE grant, ISSUE, ARM, ACK.
  localparam int unsigned SCHED_OVERHEAD = 4;

endpackage

// File: rtl/sha256_rr_arbiter.sv
// Combinational rotating-priority arbiter: the search starts at ptr and wraps.
module sha256_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W-1:0] cand;

  // First active requester at or after ptr, modulo NUM_REQ.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((32'(ptr) + i) % NUM_REQ);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/sha256_job_scheduler.sv
// Shares one simplified_sha256 engine among NUM_REQ requesters.
// Build option: define SHA_SCHED_FIXED_PRIO_EN for fixed priority (lowest index
// wins, no rotating pointer); the default build is round-robin.
module sha256_job_scheduler
  import sha256_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = ADDR_W_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_input_addr,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_hash_addr,
  output logic [NUM_REQ-1:0]          ack,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        err,
  output logic                        eng_start,
  output logic [ADDR_W-1:0]           eng_input_addr,
  output logic [ADDR_W-1:0]           eng_hash_addr,
  input  logic                        eng_done
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  sched_state_t        state_q, state_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [NUM_REQ-1:0]  owner_q, owner_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic                start_q, start_d;
  logic [IDX_W-1:0]    gid_q, gid_d;
  logic [ADDR_W-1:0]   in_addr_q, in_addr_d;
  logic [ADDR_W-1:0]   hash_addr_q, hash_addr_d;

  logic [IDX_W-1:0]    ptr;
  logic [NUM_REQ-1:0]  arb_gnt;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_any;

  logic [ADDR_W-1:0]   in_arr   [NUM_REQ];
  logic [ADDR_W-1:0]   hash_arr [NUM_REQ];

  // Unpack the flat per-requester address buses.
  for (genvar i = 0; i < int'(NUM_REQ); i++) begin : g_unpack
    assign in_arr[i]   = req_input_addr[i*ADDR_W +: ADDR_W];
    assign hash_arr[i] = req_hash_addr[i*ADDR_W +: ADDR_W];
  end

  sha256_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

`ifdef SHA_SCHED_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [IDX_W-1:0] ptr_q, ptr_d;

  assign ptr = ptr_q;

  // Pointer moves past the owner only on a completed job, never on an abort.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == S_ACK) begin
      ptr_d = (gid_q == IDX_W'(NUM_REQ - 1)) ? '0 : gid_q + IDX_W'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`endif

  // Next-state and next-output decode; req is only looked at in IDLE.
  always_comb begin
    state_d     = state_q;
    ack_d       = '0;
    start_d     = 1'b0;
    busy_d      = busy_q;
    err_d       = err_q;
    gid_d       = gid_q;
    owner_d     = owner_q;
    in_addr_d   = in_addr_q;
    hash_addr_d = hash_addr_q;
    case (state_q)
      S_IDLE: begin
        if (arb_any && eng_done) begin
          state_d     = S_ISSUE;
          start_d     = 1'b1;
          busy_d      = 1'b1;
          gid_d       = arb_idx;
          owner_d     = arb_gnt;
          in_addr_d   = in_arr[arb_idx];
          hash_addr_d = hash_arr[arb_idx];
        end
      end
      S_ISSUE: state_d = S_ARM;
      S_ARM: begin
        if (eng_done) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (eng_done) begin
          ack_d   = owner_q;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ack_q       <= '0;
      owner_q     <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      start_q     <= 1'b0;
      gid_q       <= '0;
      in_addr_q   <= '0;
      hash_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      start_q     <= start_d;
      gid_q       <= gid_d;
      in_addr_q   <= in_addr_d;
      hash_addr_q <= hash_addr_d;
    end
  end

  assign ack            = ack_q;
  assign busy           = busy_q;
  assign grant_id       = gid_q;
  assign err            = err_q;
  assign eng_start      = start_q;
  assign eng_input_addr = in_addr_q;
  assign eng_hash_addr  = hash_addr_q;

endmodule

// File: tb/tb_sha256_job_scheduler.sv
// Bench for sha256_job_scheduler: directed scenarios, an engine stand-in, and a
// job-level reference model compared against the DUT every cycle.
module tb_sha256_job_scheduler;
  import sha256_sched_pkg::*;

  localparam int unsigned NUM = 4;
  localparam int unsigned AW  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NUM-1:0]    req = '0;
  logic [NUM*AW-1:0] req_input_addr = '0;
  logic [NUM*AW-1:0] req_hash_addr = '0;
  logic [NUM-1:0]    ack;
  logic              busy;
  logic [1:0]        grant_id;
  logic              err;
  logic              eng_start;
  logic [AW-1:0]     eng_input_addr;
  logic [AW-1:0]     eng_hash_addr;
  logic              eng_done = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sha256_job_scheduler #(.NUM_REQ(NUM), .ADDR_W(AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (req),
    .req_input_addr (req_input_addr),
    .req_hash_addr  (req_hash_addr),
    .ack            (ack),
    .busy           (busy),
    .grant_id       (grant_id),
    .err            (err),
    .eng_start      (eng_start),
    .eng_input_addr (eng_input_addr),
    .eng_hash_addr  (eng_hash_addr),
    .eng_done       (eng_done)
  );

  // Engine stand-in. mode 0: normal job of eng_len cycles; 1: ignores start
  // (done stays high); 2: done held low.
  int          eng_mode = 0;
  int unsigned eng_len = 5;
  int unsigned eng_cnt = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      eng_cnt  <= 0;
      eng_done <= (eng_mode != 2);
    end else if (eng_mode == 2) begin
      eng_cnt  <= 0;
      eng_done <= 1'b0;
    end else if (eng_cnt != 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) eng_done <= 1'b1;
    end else begin
      eng_done <= 1'b1;
      if (eng_mode == 0 && eng_start && eng_done) begin
        eng_done <= 1'b0;
        eng_cnt  <= eng_len;
      end
    end
  end

  // Reference model: job-level view of the expected outputs for the next cycle.
  logic [NUM-1:0] m_ack = '0;
  logic           m_busy = 1'b0;
  logic           m_err = 1'b0;
  logic           m_start = 1'b0;
  int unsigned    m_gid = 0;
  int unsigned    m_ptr = 0;
  int unsigned    m_age = 0;
  logic [AW-1:0]  m_in = '0;
  logic [AW-1:0]  m_hash = '0;
  bit             m_job = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs the DUT will sample.
  task automatic model_step();
    int unsigned w;
    if (!rst_n) begin
      m_ack = '0; m_busy = 1'b0; m_err = 1'b0; m_start = 1'b0;
      m_gid = 0; m_ptr = 0; m_age = 0; m_in = '0; m_hash = '0; m_job = 1'b0;
      return;
    end
    m_start = 1'b0;
    if (m_ack != '0) begin
      // job just completed: owner released, next search starts after it
      m_ack  = '0;
      m_busy = 1'b0;
      m_job  = 1'b0;
`ifndef SHA_SCHED_FIXED_PRIO_EN
      m_ptr = (m_gid + 1) % NUM;
`endif
    end else if (!m_job) begin
      if (req != '0 && eng_done) begin
        for (int j = 0; j < int'(NUM); j++) begin
          w = (m_ptr + 32'(j)) % NUM;
          if (!m_job && req[2'(w)]) begin
            m_job  = 1'b1;
            m_gid  = w;
            m_in   = req_input_addr[w*AW +: AW];
            m_hash = req_hash_addr[w*AW +: AW];
          end
        end
        m_age   = 0;
        m_start = 1'b1;
        m_busy  = 1'b1;
      end
    end else begin
      // age 1 = start cycle, 2 = engine must have left idle, 3+ = wait for done
      m_age++;
      if (m_age == 2 && eng_done) begin
        m_err  = 1'b1;
        m_busy = 1'b0;
        m_job  = 1'b0;
      end else if (m_age >= 3 && eng_done) begin
        m_ack = NUM'(1) << m_gid;
      end
    end
  endtask

  task automatic compare();
    chk("ack",            32'(ack),            32'(m_ack));
    chk("busy",           32'(busy),           32'(m_busy));
    chk("grant_id",       32'(grant_id),       32'(m_gid));
    chk("err",            32'(err),            32'(m_err));
    chk("eng_start",      32'(eng_start),      32'(m_start));
    chk("eng_input_addr", 32'(eng_input_addr), 32'(m_in));
    chk("eng_hash_addr",  32'(eng_hash_addr),  32'(m_hash));
  endtask

  // One clock: model consumes current inputs, then outputs are checked mid-cycle.
  task automatic tick();
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic set_job(input int i, input logic [AW-1:0] ia, input logic [AW-1:0] ha);
    req_input_addr[i*AW +: AW] = ia;
    req_hash_addr[i*AW +: AW]  = ha;
  endtask

  task automatic wait_ack(input string name, input int limit, output int seen);
    seen = 0;
    for (int c = 0; c < limit && seen == 0; c++) begin
      tick();
      if (ack != '0) seen = 1;
    end
    chk(name, 32'(seen), 32'(1));
  endtask

  initial begin
    int n, seen, rise_n, ack_n, hits;
    logic prev_done;
    int exp_seq [5];

`ifdef SHA_SCHED_FIXED_PRIO_EN
    exp_seq = '{0, 0, 0, 0, 0};
`else
    exp_seq = '{0, 1, 2, 3, 0};
`endif

    // reset
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_grant_id", 32'(grant_id), 32'(0));
    rst_n = 1'b1;
    tick();

    // single job on requester 2, 300-cycle engine
    eng_len = 300;
    set_job(2, 16'h0000, 16'h00A0);
    req[2] = 1'b1;
    n = 1;
    chk("t1_start_early", 32'(eng_start), 32'(0));
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      tick(); n++;
      if (eng_start) seen = 1;
    end
    chk("t1_start_seen", 32'(seen), 32'(1));
    chk("t1_req_to_start", 32'(n), 32'(2));
    rise_n = 0; ack_n = 0; prev_done = eng_done;
    for (int c = 0; c < 400 && ack_n == 0; c++) begin
      tick(); n++;
      if (eng_done && !prev_done) rise_n = n;
      prev_done = eng_done;
      if (ack != '0) ack_n = n;
      if (n == 150) chk("t1_mid_hash", 32'(eng_hash_addr), 32'h00A0);
    end
    chk("t1_ack_onehot", 32'(ack), 32'h4);
    chk("t1_done_to_ack", 32'(ack_n - rise_n), 32'(1));
    chk("t1_job_cycles", 32'(n), 32'(300 + SCHED_OVERHEAD));
    chk("t1_in_addr", 32'(eng_input_addr), 32'h0000);
    chk("t1_hash_addr", 32'(eng_hash_addr), 32'h00A0);
    req[2] = 1'b0;
    tick(); tick();
    chk("t1_no_regrant", 32'(busy), 32'(0));

    // all four requesting, each immediately posting a new job after its ack
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    eng_len = 5;
    for (int i = 0; i < int'(NUM); i++) set_job(i, AW'(16'h1000 + 16'(i)), AW'(16'h2000 + 16'(i)));
    req = '1;
    for (int k = 0; k < 5; k++) begin
      wait_ack("t2_ack_seen", 60, seen);
      chk("t2_ack_owner", 32'(ack), 32'(1) << exp_seq[k]);
      chk("t2_grant_id", 32'(grant_id), 32'(exp_seq[k]));
    end
    req = '0;
    tick(); tick();

    // requester 1 rewrites its addresses mid-job
    eng_len = 10;
    set_job(1, 16'h1234, 16'h5678);
    req[1] = 1'b1;
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      tick();
      if (eng_start) seen = 1;
    end
    chk("t3_start_seen", 32'(seen), 32'(1));
    tick();
    set_job(1, 16'hFFFF, 16'hEEEE);
    wait_ack("t3_ack_seen", 40, seen);
    chk("t3_ack_owner", 32'(ack), 32'h2);
    chk("t3_in_addr", 32'(eng_input_addr), 32'h1234);
    chk("t3_hash_addr", 32'(eng_hash_addr), 32'h5678);
    req[1] = 1'b0;
    tick(); tick();

    // engine stays idle after start: abort, retry, sticky err
    eng_mode = 1;
    set_job(3, 16'h0300, 16'h0380);
    req[3] = 1'b1;
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      tick();
      if (err) seen = 1;
    end
    chk("t4_err_seen", 32'(seen), 32'(1));
    chk("t4_busy_dropped", 32'(busy), 32'(0));
    hits = 0; n = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (ack != '0) hits++;
      if (eng_start) n++;
    end
    chk("t4_no_ack", 32'(hits), 32'(0));
    chk("t4_retried", 32'(n >= 2), 32'(1));
    eng_mode = 0;
    eng_len  = 4;
    wait_ack("t4_ack_seen", 40, seen);
    chk("t4_ack_owner", 32'(ack), 32'h8);
    req[3] = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    chk("t4_err_sticky", 32'(err), 32'(1));

    // reset while the engine is running
    eng_len = 50;
    set_job(0, 16'h0A0A, 16'h0B0B);
    req[0] = 1'b1;
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      tick();
      if (eng_start) seen = 1;
    end
    chk("t5_start_seen", 32'(seen), 32'(1));
    for (int c = 0; c < 5; c++) tick();
    chk("t5_busy_in_run", 32'(busy), 32'(1));
    rst_n = 1'b0;
    req[0] = 1'b0;
    tick();
    chk("t5_rst_busy", 32'(busy), 32'(0));
    chk("t5_rst_err", 32'(err), 32'(0));
    chk("t5_rst_in_addr", 32'(eng_input_addr), 32'(0));
    chk("t5_rst_hash_addr", 32'(eng_hash_addr), 32'(0));
    rst_n = 1'b1;
    hits = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (ack != '0) hits++;
    end
    chk("t5_no_ack", 32'(hits), 32'(0));

    // engine not idle: requests wait
    eng_mode = 2;
    eng_len  = 5;
    tick(); tick();
    set_job(2, 16'h0042, 16'h0084);
    req[2] = 1'b1;
    hits = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (busy || eng_start) hits++;
    end
    chk("t6_no_grant", 32'(hits), 32'(0));
    eng_mode = 0;
    tick();
    chk("t6_done_back", 32'(eng_done), 32'(1));
    chk("t6_still_idle", 32'(busy), 32'(0));
    tick();
    chk("t6_granted", 32'(busy), 32'(1));
    chk("t6_grant_id", 32'(grant_id), 32'(2));
    wait_ack("t6_ack_seen", 40, seen);
    chk("t6_ack_owner", 32'(ack), 32'h4);
    req[2] = 1'b0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
